alu_cmd_issuer: RTL and testbench

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_cmd_issuer.sv | 202 ++++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
`timescale 1ns/1ps
// alu_cmd_issuer: buffers ALU commands in a small FIFO, then issues them one
// at a time to a registered ALU. Each result is returned with its tag, in the
// order the commands were accepted. Illegal opcodes skip the ALU and are
// answered with an error.
module alu_cmd_issuer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_tag,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_ctrl,
  input  logic [31:0] alu_y,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_n,
  input  logic        alu_c,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_y,
  output logic [3:0]  res_flags,
  output logic [3:0]  res_tag,
  output logic        res_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(SETTLE + 1);
  localparam int EW = 73;
  localparam logic [AW:0] FILL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FILL_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_fill;
  logic [CW-1:0] r_settleCnt;
  logic [31:0]   r_aluA;
  logic [31:0]   r_aluB;
  logic [4:0]    r_aluCtrl;
  logic [31:0]   r_resY;
  logic [3:0]    r_resFlags;
  logic [3:0]    r_resTag;
  logic          r_resErr;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_loadAlu;
  logic          w_loadErr;
  logic          w_capture;
  logic [EW-1:0] w_head;
  logic [4:0]    w_headOp;
  logic [31:0]   w_headA;
  logic [31:0]   w_headB;
  logic [3:0]    w_headTag;

  // Legal opcodes: 000xx, 01000-01101, 10000-10010, 110xx.
  function automatic logic isLegal(input logic [4:0] op);
    logic ok;
    ok = 1'b0;
    case (op[4:3])
      2'b00:   ok = ~op[2];
      2'b01:   ok = (op[2:0] <= 3'd5);
      2'b10:   ok = (op[2:0] <= 3'd2);
      default: ok = ~op[2];
    endcase
    return ok;
  endfunction

  assign w_full    = (r_fill == FILL_FULL);
  assign w_empty   = (r_fill == '0);
  assign cmd_ready = ~w_full;
  assign w_push    = cmd_valid & cmd_ready;
  assign w_head    = r_mem[r_rdPtr];
  assign w_headOp  = w_head[72:68];
  assign w_headA   = w_head[67:36];
  assign w_headB   = w_head[35:4];
  assign w_headTag = w_head[3:0];

  assign alu_a     = r_aluA;
  assign alu_b     = r_aluB;
  assign alu_ctrl  = r_aluCtrl;
  assign res_valid = (r_state == ST_RESP);
  assign res_y     = r_resY;
  assign res_flags = r_resFlags;
  assign res_tag   = r_resTag;
  assign res_err   = r_resErr;

  // Command storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {cmd_op, cmd_a, cmd_b, cmd_tag};
    end
  end

  // FIFO pointers and fill level; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_fill  <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + FILL_ONE;
        2'b01:   r_fill <= r_fill - FILL_ONE;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Issue state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // Next state and control strobes: one command in flight at a time.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_loadAlu   = 1'b0;
    w_loadErr   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (isLegal(w_headOp)) begin
            w_loadAlu   = 1'b1;
            w_nextState = ST_WAIT;
          end else begin
            w_loadErr   = 1'b1;
            w_nextState = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (r_settleCnt <= CNT_ONE) begin
          w_capture   = 1'b1;
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // ALU drive, settle counter and result capture; flags only pass through for op[4:3]==00.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluCtrl   <= '0;
      r_settleCnt <= '0;
      r_resY      <= '0;
      r_resFlags  <= '0;
      r_resTag    <= '0;
      r_resErr    <= 1'b0;
    end else begin
      if (w_loadAlu) begin
        r_aluA      <= w_headA;
        r_aluB      <= w_headB;
        r_aluCtrl   <= w_headOp;
        r_settleCnt <= CNT_LOAD;
      end else if (r_state == ST_WAIT) begin
        r_settleCnt <= r_settleCnt - CNT_ONE;
      end
      if (w_loadAlu || w_loadErr) begin
        r_resTag <= w_headTag;
      end
      if (w_loadErr) begin
        r_resY     <= '0;
        r_resFlags <= '0;
        r_resErr   <= 1'b1;
      end else if (w_capture) begin
        r_resY     <= alu_y;
        r_resFlags <= (r_aluCtrl[4:3] == 2'b00) ? {alu_z, alu_v, alu_n, alu_c} : 4'b0000;
        r_resErr   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
`timescale 1ns/1ps
// tb_alu_cmd_issuer: directed commands through a behavioral registered ALU;
// expected results are queued on acceptance and checked by a separate monitor.
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_tag;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_y;
  logic        alu_z;
  logic        alu_v;
  logic        alu_n;
  logic        alu_c;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_y;
  logic [3:0]  res_flags;
  logic [3:0]  res_tag;
  logic        res_err;

  typedef struct {
    logic [31:0] y;
    logic [3:0]  flags;
    logic [3:0]  tag;
    logic        err;
  } expRes_t;

  expRes_t expQ[$];
  int      total = 0;
  int      bad   = 0;

  alu_cmd_issuer #(.DEPTH(4), .SETTLE(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_y(alu_y), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
    .res_flags(res_flags), .res_tag(res_tag), .res_err(res_err)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Behavioral ALU: 00000 add, 00001 sign-magnitude subtract, 01000 AND, others XOR.
  function automatic logic [35:0] aluCalc(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    logic [31:0] y;
    logic        v;
    logic        c;
    sum = 33'd0;
    y   = 32'd0;
    v   = 1'b0;
    c   = 1'b0;
    case (op)
      5'b00000: begin
        sum = {1'b0, a} + {1'b0, b};
        y   = sum[31:0];
        c   = sum[32];
        v   = (a[31] == b[31]) && (y[31] != a[31]);
      end
      5'b00001: y = (a >= b) ? (a - b) : {1'b1, 31'(b - a)};
      5'b01000: y = a & b;
      default:  y = a ^ b;
    endcase
    return {y, (y == 32'd0), v, y[31], c};
  endfunction

  // The ALU registers its result one edge after its inputs change.
  always @(posedge clk) begin
    {alu_y, alu_z, alu_v, alu_n, alu_c} <= aluCalc(alu_ctrl, alu_a, alu_b);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Offer one command; queue its expected result on the accepting edge.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] tag, input logic [31:0] expY,
                               input logic [3:0] expFlags, input logic expErr);
    bit      done;
    expRes_t e;
    done      = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        done = 1'b1;
        @(posedge clk);
        e.y = expY; e.flags = expFlags; e.tag = tag; e.err = expErr;
        expQ.push_back(e);
      end else begin
        @(posedge clk);
      end
      #2;
    end
    cmd_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: tag=%0d never accepted, required acceptance", tag);
    end
  endtask

  task automatic drainWait(input string what);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain_%s: pending=%0d required=0", what, expQ.size());
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: every accepted result is compared against the head of the queue.
  always @(negedge clk) begin
    expRes_t e;
    if (!rst && res_valid && res_ready) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: tag=%0d y=0x%08h, required no result", res_tag, res_y);
      end else begin
        e = expQ.pop_front();
        checkOutput("res_y", res_y, e.y);
        checkOutput("res_flags", 32'(res_flags), 32'(e.flags));
        checkOutput("res_tag", 32'(res_tag), 32'(e.tag));
        checkOutput("res_err", 32'(res_err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    bit started;
    // Reset with a push attempt that must be ignored.
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 5'b00000;
    cmd_a     = 32'd100;
    cmd_b     = 32'd200;
    cmd_tag   = 4'd9;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    checkOutput("rst_res_y", res_y, 32'd0);
    @(posedge clk);
    #2;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("rst_push_ignored_alu_a", alu_a, 32'd0);
    checkOutput("rst_push_ignored_res_valid", 32'(res_valid), 32'd0);
    @(posedge clk);
    #2;

    // ADD 5+3 and its latency from ALU load to res_valid.
    applyStimulus(5'b00000, 32'd5, 32'd3, 4'd1, 32'd8, 4'b0000, 1'b0);
    started = 1'b0;
    lat     = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (alu_a == 32'd5 && alu_b == 32'd3) started = 1'b1;
      if (started) lat++;
      if (res_valid) break;
    end
    checkOutput("add_latency", 32'(lat), 32'd3);
    drainWait("add");

    // Sign-magnitude subtract, then an illegal op that must leave alu_* alone.
    applyStimulus(5'b00001, 32'd3, 32'd5, 4'd2, 32'h80000002, 4'b0010, 1'b0);
    applyStimulus(5'b01110, 32'd9, 32'd9, 4'd7, 32'd0, 4'b0000, 1'b1);
    drainWait("illegal");
    checkOutput("illegal_alu_ctrl_hold", 32'(alu_ctrl), 32'd1);
    checkOutput("illegal_alu_a_hold", alu_a, 32'd3);

    // Opcode boundaries and flag pass-through rules, queued back-to-back.
    applyStimulus(5'b00011, 32'd7, 32'd7, 4'd4, 32'd0, 4'b1000, 1'b0);
    applyStimulus(5'b10010, 32'hAAAA, 32'hAAAA, 4'd5, 32'd0, 4'b0000, 1'b0);
    applyStimulus(5'b11011, 32'h12345678, 32'h0000FFFF, 4'd6, 32'h1234A987, 4'b0000, 1'b0);
    applyStimulus(5'b01101, 32'hFFFF0000, 32'h0000FFFF, 4'd8, 32'hFFFFFFFF, 4'b0000, 1'b0);
    applyStimulus(5'b00000, 32'h7FFFFFFF, 32'd1, 4'd9, 32'h80000000, 4'b0110, 1'b0);
    applyStimulus(5'b00000, 32'hFFFFFFFF, 32'd1, 4'd10, 32'd0, 4'b1001, 1'b0);
    applyStimulus(5'b00100, 32'd1, 32'd1, 4'd11, 32'd0, 4'b0000, 1'b1);
    applyStimulus(5'b01111, 32'd1, 32'd1, 4'd12, 32'd0, 4'b0000, 1'b1);
    applyStimulus(5'b10011, 32'd1, 32'd1, 4'd13, 32'd0, 4'b0000, 1'b1);
    applyStimulus(5'b10111, 32'd1, 32'd1, 4'd14, 32'd0, 4'b0000, 1'b1);
    applyStimulus(5'b11100, 32'd1, 32'd1, 4'd15, 32'd0, 4'b0000, 1'b1);
    applyStimulus(5'b10000, 32'd1, 32'd2, 4'd0, 32'd3, 4'b0000, 1'b0);
    applyStimulus(5'b11000, 32'd5, 32'd5, 4'd3, 32'd0, 4'b0000, 1'b0);
    drainWait("boundaries");

    // Backpressure: one in flight plus four queued, sixth must stall.
    res_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(5'b00000, 32'(i), 32'(i), 4'(i), 32'(2 * i), 4'b0000, 1'b0);
    end
    cmd_valid = 1'b1;
    cmd_op    = 5'b00000;
    cmd_a     = 32'd6;
    cmd_b     = 32'd6;
    cmd_tag   = 4'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("full_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("held_res_valid", 32'(res_valid), 32'd1);
      checkOutput("held_res_tag", 32'(res_tag), 32'd1);
    end
    @(posedge clk);
    #2;
    res_ready = 1'b1;
    applyStimulus(5'b00000, 32'd6, 32'd6, 4'd6, 32'd12, 4'b0000, 1'b0);
    drainWait("backpressure");

    // Reset one cycle into WAIT with two commands still queued.
    applyStimulus(5'b00000, 32'h11, 32'h22, 4'd1, 32'h33, 4'b0000, 1'b0);
    applyStimulus(5'b00000, 32'h44, 32'h55, 4'd2, 32'h99, 4'b0000, 1'b0);
    applyStimulus(5'b00000, 32'h66, 32'h77, 4'd3, 32'hDD, 4'b0000, 1'b0);
    rst = 1'b1;
    expQ.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midwait_alu_a", alu_a, 32'd0);
    checkOutput("midwait_alu_b", alu_b, 32'd0);
    checkOutput("midwait_res_y", res_y, 32'd0);
    checkOutput("midwait_res_tag", 32'(res_tag), 32'd0);
    checkOutput("midwait_res_flags", 32'(res_flags), 32'd0);
    checkOutput("midwait_res_err", 32'(res_err), 32'd0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("midwait_res_valid", 32'(res_valid), 32'd0);
      checkOutput("midwait_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("midwait_alu_ctrl", 32'(alu_ctrl), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #2;

    // AND after recovery from reset.
    applyStimulus(5'b01000, 32'hF0F0F0F0, 32'hFF00FF00, 4'hC, 32'hF000F000, 4'b0000, 1'b0);
    drainWait("and");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
